contactor_sequencer: RTL and testbench

Downstream consumer of the SOA monitor's `soa_violation` flag. It sequences the pack's main contactors through precharge into closed operation and opens them on a debounced SOA violation. It latches the trip and re-arms only on an explicit clear, or optionally by timed auto-retry. Its outputs drive the contactor coil drivers and the BMS status register.

---
 rtl/contactor_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_contactor_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/contactor_sequencer.sv
// contactor_sequencer
// Sequences the pack main contactors IDLE -> PRECHARGE -> CLOSED and opens
// them on a debounced SOA violation. A trip latches in FAULT until an
// explicit fault_clear while the violation is low.
// Optional feature macro: CONTACTOR_AUTO_RETRY_EN (timed auto-retry from
// FAULT, bounded by MAX_RETRIES). Default build has no auto-retry.
module contactor_sequencer #(
    parameter logic [15:0] PRECHARGE_CYCLES = 16'd1000,
    parameter logic [3:0]  DEBOUNCE_CYCLES  = 4'd4,
    parameter logic [15:0] RETRY_CYCLES     = 16'd5000,
    parameter logic [1:0]  MAX_RETRIES      = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       soa_violation,
    input  logic       drive_req,
    input  logic       fault_clear,
    output logic       precharge_close,
    output logic       main_neg_close,
    output logic       main_pos_close,
    output logic       trip_latched,
    output logic [1:0] state_o,
    output logic [3:0] trip_count
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRECHARGE = 2'd1;
    localparam logic [1:0] ST_CLOSED    = 2'd2;
    localparam logic [1:0] ST_FAULT     = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  viol_cnt_q, viol_cnt_d;
    logic [15:0] pc_tmr_q, pc_tmr_d;
    logic [3:0]  trip_cnt_q, trip_cnt_d;

    logic trip;
    logic pc_done;
    logic clear_ok;
    logic retry_fire;
    logic coils_live;

    // Nth consecutive high sample of the violation flag.
    assign trip       = soa_violation && (viol_cnt_q == (DEBOUNCE_CYCLES - 4'd1));
    assign pc_done    = (pc_tmr_q == (PRECHARGE_CYCLES - 16'd1));
    assign clear_ok   = (state_q == ST_FAULT) && fault_clear && !soa_violation;
    assign coils_live = (state_q == ST_PRECHARGE) || (state_q == ST_CLOSED);

    // Debounce counter: counts consecutive violation samples, saturating.
    always_comb begin
        viol_cnt_d = viol_cnt_q;
        if (soa_violation) begin
            if (viol_cnt_q < DEBOUNCE_CYCLES) begin
                viol_cnt_d = viol_cnt_q + 4'd1;
            end
        end else begin
            viol_cnt_d = '0;
        end
    end

`ifdef CONTACTOR_AUTO_RETRY_EN
    logic [15:0] retry_tmr_q, retry_tmr_d;
    logic [1:0]  retry_cnt_q, retry_cnt_d;
    logic        retry_expired;

    assign retry_expired = (state_q == ST_FAULT) && !soa_violation &&
                           (retry_tmr_q == (RETRY_CYCLES - 16'd1));
    assign retry_fire    = retry_expired && (retry_cnt_q < MAX_RETRIES);

    // Retry timer counts clean FAULT cycles; holds at expiry once retries run out.
    always_comb begin
        retry_tmr_d = '0;
        if ((state_q == ST_FAULT) && (state_d == ST_FAULT) && !soa_violation) begin
            retry_tmr_d = retry_expired ? retry_tmr_q : retry_tmr_q + 16'd1;
        end
    end

    // Retry budget: consumed by each auto-retry, restored by a manual clear.
    always_comb begin
        retry_cnt_d = retry_cnt_q;
        if (clear_ok) begin
            retry_cnt_d = '0;
        end else if (retry_fire) begin
            retry_cnt_d = retry_cnt_q + 2'd1;
        end
    end

    // Retry state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retry_tmr_q <= '0;
            retry_cnt_q <= '0;
        end else begin
            retry_tmr_q <= retry_tmr_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end
`else
    logic unused_retry_cfg;

    assign retry_fire       = 1'b0;
    assign unused_retry_cfg = ^{RETRY_CYCLES, MAX_RETRIES};
`endif

    // Next-state logic; a trip outranks a dropped drive request and timer expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!trip && drive_req && !soa_violation && (viol_cnt_q == 4'd0)) begin
                    state_d = ST_PRECHARGE;
                end
            end
            ST_PRECHARGE: begin
                if (trip) begin
                    state_d = ST_FAULT;
                end else if (!drive_req) begin
                    state_d = ST_IDLE;
                end else if (pc_done) begin
                    state_d = ST_CLOSED;
                end
            end
            ST_CLOSED: begin
                if (trip) begin
                    state_d = ST_FAULT;
                end else if (!drive_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (clear_ok || retry_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Precharge timer: zero on entry, advances each cycle spent in PRECHARGE.
    always_comb begin
        pc_tmr_d = '0;
        if ((state_q == ST_PRECHARGE) && (state_d == ST_PRECHARGE)) begin
            pc_tmr_d = pc_tmr_q + 16'd1;
        end
    end

    // Trip counter: counts only trips that actually opened closed coils.
    always_comb begin
        trip_cnt_d = trip_cnt_q;
        if (coils_live && trip && (trip_cnt_q != 4'hF)) begin
            trip_cnt_d = trip_cnt_q + 4'd1;
        end
    end

    // Core state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            viol_cnt_q <= '0;
            pc_tmr_q   <= '0;
            trip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            viol_cnt_q <= viol_cnt_d;
            pc_tmr_q   <= pc_tmr_d;
            trip_cnt_q <= trip_cnt_d;
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        precharge_close = 1'b0;
        main_neg_close  = 1'b0;
        main_pos_close  = 1'b0;
        trip_latched    = 1'b0;
        unique case (state_q)
            ST_PRECHARGE: begin
                precharge_close = 1'b1;
                main_neg_close  = 1'b1;
            end
            ST_CLOSED: begin
                main_neg_close  = 1'b1;
                main_pos_close  = 1'b1;
            end
            ST_FAULT: begin
                trip_latched    = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o    = state_q;
    assign trip_count = trip_cnt_q;

    // Coil overlap invariants guarding the contactor hardware.
    a_no_pc_with_pos: assert property (@(posedge clk) disable iff (!rst_n)
        !(precharge_close && main_pos_close));
    a_pos_needs_neg: assert property (@(posedge clk) disable iff (!rst_n)
        (main_pos_close |-> main_neg_close));

endmodule

// File: tb/tb_contactor_sequencer.sv
// Directed table-driven bench for contactor_sequencer with
// PRECHARGE_CYCLES=8, DEBOUNCE_CYCLES=4, RETRY_CYCLES=10, MAX_RETRIES=3.
module tb_contactor_sequencer;

    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_P = 2'd1;
    localparam logic [1:0] S_C = 2'd2;
    localparam logic [1:0] S_F = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       soa_violation = 1'b0;
    logic       drive_req = 1'b0;
    logic       fault_clear = 1'b0;
    logic       precharge_close, main_neg_close, main_pos_close, trip_latched;
    logic [1:0] state_o;
    logic [3:0] trip_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       rst_n;
        logic       soa;
        logic       dr;
        logic       fc;
        logic [1:0] st;
        int         tc;
    } vec_t;

    vec_t vecs[$];

    contactor_sequencer #(
        .PRECHARGE_CYCLES(16'd8),
        .DEBOUNCE_CYCLES (4'd4),
        .RETRY_CYCLES    (16'd10),
        .MAX_RETRIES     (2'd3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .soa_violation   (soa_violation),
        .drive_req       (drive_req),
        .fault_clear     (fault_clear),
        .precharge_close (precharge_close),
        .main_neg_close  (main_neg_close),
        .main_pos_close  (main_pos_close),
        .trip_latched    (trip_latched),
        .state_o         (state_o),
        .trip_count      (trip_count)
    );

    always #5 clk = ~clk;

    task automatic add(input int n, input logic r, input logic s, input logic d,
                       input logic f, input logic [1:0] st, input int tc);
        vec_t v;
        v.rst_n = r; v.soa = s; v.dr = d; v.fc = f; v.st = st; v.tc = tc;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic s, input logic d, input logic f);
        rst_n = r; soa_violation = s; drive_req = d; fault_clear = f;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [1:0] st,
                           input int tc);
        chk({tag, ".state"},     idx, 32'(state_o),         32'(st));
        chk({tag, ".pc_close"},  idx, 32'(precharge_close), 32'(st == S_P));
        chk({tag, ".neg_close"}, idx, 32'(main_neg_close),  32'((st == S_P) || (st == S_C)));
        chk({tag, ".pos_close"}, idx, 32'(main_pos_close),  32'(st == S_C));
        chk({tag, ".trip_lat"},  idx, 32'(trip_latched),    32'(st == S_F));
        chk({tag, ".trip_cnt"},  idx, 32'(trip_count),      32'(tc));
    endtask

    initial begin
        int tc;
        int n;

        // ---------------- vector table ----------------
        add(2, 0, 0, 0, 0, S_I, 0);          // reset state
        add(8, 1, 0, 1, 0, S_P, 0);          // exactly 8 cycles of precharge
        add(2, 1, 0, 1, 0, S_C, 0);
        add(3, 1, 1, 1, 0, S_C, 0);          // 3-sample glitch: no trip
        add(1, 1, 0, 1, 0, S_C, 0);
        add(3, 1, 1, 1, 0, S_C, 0);
        add(1, 1, 1, 1, 0, S_F, 1);          // trip on 4th sample
        add(1, 1, 1, 1, 1, S_F, 1);          // clear ignored while violating
        add(1, 1, 1, 1, 0, S_F, 1);
        add(1, 1, 0, 1, 0, S_F, 1);          // clean, no clear: latched
        add(1, 1, 0, 1, 1, S_I, 1);          // clear accepted
        add(3, 1, 0, 1, 0, S_P, 1);          // fresh precharge
        add(1, 1, 0, 0, 0, S_I, 1);          // drop mid-precharge, count unchanged
        add(5, 1, 0, 1, 0, S_P, 1);          // entry + 4 more
        add(3, 1, 1, 1, 0, S_P, 1);
        add(1, 1, 1, 1, 0, S_F, 2);          // trip on timer-expiry edge wins
        add(1, 1, 0, 0, 1, S_I, 2);
        add(5, 1, 1, 0, 0, S_I, 2);          // trip in IDLE is not counted
        add(1, 1, 1, 1, 0, S_I, 2);          // blocked while violating
        add(1, 1, 0, 1, 0, S_I, 2);          // blocked while debounce count nonzero
        add(8, 1, 0, 1, 0, S_P, 2);
        add(1, 1, 0, 1, 0, S_C, 2);
        add(3, 1, 1, 1, 0, S_C, 2);
        add(1, 1, 1, 0, 0, S_F, 3);          // trip with drive_req falling: FAULT
        add(1, 1, 0, 0, 1, S_I, 3);
        add(1, 1, 0, 0, 1, S_I, 3);          // clear in IDLE is a no-op
        add(8, 1, 0, 1, 0, S_P, 3);
        add(1, 1, 0, 1, 0, S_C, 3);
        add(1, 1, 0, 1, 1, S_C, 3);          // clear in CLOSED ignored
        add(1, 0, 0, 1, 0, S_I, 0);          // reset mid-operation
        add(1, 1, 0, 1, 0, S_P, 0);
        add(1, 1, 0, 0, 0, S_I, 0);
        tc = 0;
        for (int t = 0; t < 16; t++) begin   // 16 trips, count saturates at 15
            add(1, 1, 0, 1, 0, S_P, tc);
            add(3, 1, 1, 1, 0, S_P, tc);
            tc = (tc < 15) ? tc + 1 : 15;
            add(1, 1, 1, 1, 0, S_F, tc);
            add(1, 1, 0, 1, 1, S_I, tc);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].soa, vecs[i].dr, vecs[i].fc);
            chk_all("vec", i, vecs[i].st, vecs[i].tc);
        end

`ifdef CONTACTOR_AUTO_RETRY_EN
        // ---------------- auto-retry sequence ----------------
        step(0, 0, 0, 0);
        chk_all("retry.reset", 0, S_I, 0);
        for (int r = 0; r < 4; r++) begin
            n = 0;
            for (int k = 1; k <= 20; k++) begin
                step(1, 0, 1, 0);
                n = k;
                if (state_o == S_C) break;
            end
            chk("retry.connect_cycles", r, 32'(n), 32'd9);
            for (int k = 0; k < 4; k++) step(1, 1, 1, 0);
            chk_all("retry.trip", r, S_F, r + 1);
            n = 0;
            for (int k = 1; k <= 30; k++) begin
                step(1, 0, 1, 0);
                n = k;
                if (state_o != S_F) break;
            end
            if (r < 3) begin
                chk("retry.clean_cycles", r, 32'(n), 32'd10);
                chk_all("retry.idle", r, S_I, r + 1);
            end else begin
                chk("retry.exhausted_cycles", r, 32'(n), 32'd30);
                chk_all("retry.held", r, S_F, 4);
                step(1, 0, 1, 1);
                chk_all("retry.manual_clear", r, S_I, 4);
            end
        end
`else
        // ---------------- no auto-retry: FAULT holds without a clear ----------------
        step(1, 0, 1, 0);
        chk_all("hold.enter", 0, S_P, 15);
        for (int k = 0; k < 3; k++) step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        chk_all("hold.trip", 0, S_F, 15);
        for (int k = 0; k < 25; k++) begin
            step(1, 0, 1, 0);
            chk("hold.state", k, 32'(state_o), 32'(S_F));
        end
        step(1, 0, 1, 1);
        chk_all("hold.clear", 0, S_I, 15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
